mips_run_monitor: RTL and testbench
===================================

# mips_run_monitor

Cycle-accurate run monitor that sits directly downstream of `mips_cpu_harvard` in every CPU bench and in the FPGA smoke harness. It watches `active`, `instr_address` and `register_v0`, and counts cycles and fetches from the reset vector onwards. It detects the halt sequence (jump to address 0, then `active` falling), captures the final `register_v0` and compares it with an expected value. It reports a sticky pass/fail/timeout verdict, so benches stop hand-coding negedge assertions.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'hBFC00000: first fetch address that starts a run.
- `HALT_ADDR`, default 32'h00000000: fetch address that signals halt.
- `TIMEOUT_CYCLES`, default 10000: enabled cycles allowed in RUN before timeout.
- `DRAIN_LIMIT`, default 4: enabled cycles allowed between halt fetch and `active` falling.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `clk_enable` in 1: same enable the CPU sees; the monitor advances only when it is 1.
- `active` in 1: CPU active flag.
- `instr_address` in 32: CPU fetch address.
- `register_v0` in 32: CPU $v0 debug output.
- `expected_v0` in 32: reference result; sampled at capture.
- `check_en` in 1: 1 compares the captured value with `expected_v0`; 0 passes on any clean halt.
- `done` out 1: verdict valid (sticky).
- `status` out 2: `run_status_t` verdict.
- `final_v0` out 32: captured $v0.
- `cycle_count` out 32: enabled cycles spent in RUN and DRAIN.
- `fetch_count` out 32: enabled RUN cycles with `active`=1.

## Operation
State machine `mon_state_t`:
- **IDLE**
  - Enabled cycle with `active`=1 and `instr_address`==RESET_VECTOR → RUN.
  - That same cycle counts as cycle 1 and fetch 1.
- **RUN**
  - Every enabled cycle: `cycle_count`+1. If `active`=1, also `fetch_count`+1.
  - `instr_address`==HALT_ADDR → DRAIN. The drain counter clears.
  - Otherwise, if `cycle_count` reaches TIMEOUT_CYCLES → DONE with `status`=TIMEOUT.
  - Halt detection has priority over timeout in the same cycle.
- **DRAIN**
  - Every enabled cycle: `cycle_count`+1 and drain counter +1.
  - The first enabled cycle with `active`=0:
    - `final_v0` ← `register_v0`.
    - `status` ← PASS if `check_en`=0 or `register_v0`==`expected_v0`, else FAIL.
    - → DONE.
  - Drain counter reaches DRAIN_LIMIT with `active` still 1 → DONE with `status`=HALT_ERR. `final_v0` ← `register_v0`.
- **DONE**
  - Absorbing state. All outputs are frozen and `done`=1 until reset.

Other rules:
- `active` falling while in RUN, without a halt fetch: → DONE with `status`=HALT_ERR, `final_v0` captured.
- Counters saturate at 32'hFFFFFFFF and never wrap.
- `clk_enable`=0 holds state, counters and outputs unchanged.

## Timing
- Reset asserted (async): state=IDLE, `done`=0, `status`=NONE, `final_v0`=0, both counters 0. Reset takes effect immediately, including mid-run or in DONE.
- All outputs are registered. No combinational path from inputs to outputs.
- `done` and `status` rise on the edge after the capture cycle: latency 1 enabled cycle.
- `final_v0` and `status` update on the same edge as `done`.
- A halt fetch in the same cycle as timeout is taken as a halt.
- `active`=0 in the first DRAIN cycle captures immediately, so drain latency is 1.
- If `expected_v0` changes after capture, the verdict does not change.

## Structure
- Package `mips_tb_pkg`:
  - `mon_state_t` {IDLE, RUN, DRAIN, DONE}.
  - `run_status_t` 2-bit {NONE=0, PASS=1, FAIL=2, TIMEOUT=3}.
  - HALT_ERR is reported as FAIL with `done`=1 and `fetch_count` frozen, and is additionally flagged by localparam `MON_HALT_ERR_CODE`=2.
  - Default reset vector constant.
- One sub-module, `sat_counter32`: enable plus clear, saturating. Instantiated twice for the counters. The drain counter is inline.

## Test plan
- **Clean halt, correct v0.** CPU program `addiu v0,zero,2`; `jr zero`; delay-slot `addiu`. `expected_v0`=2, `check_en`=1. Required: `done`=1, `status`=PASS, `final_v0`=2, `cycle_count` matches the CPU's cycles from 32'hBFC00000.
- **Clean halt, wrong v0.** Same program with `expected_v0`=3. Required: `status`=FAIL, `final_v0`=2.
- **Timeout.** TIMEOUT_CYCLES=20 with a self-loop program (`beq` back to itself). Required: `status`=TIMEOUT on cycle 20, `cycle_count`=20, outputs frozen afterwards.
- **Stalls during run.** Toggle `clk_enable` low for 5 cycles mid-run. Required: counters unchanged during the stall, final verdict identical to the unstalled run.
- **Reset mid-DRAIN.** Drive reset=0 one cycle after the halt fetch. Required: all outputs 0 and state=IDLE immediately. After release, a fresh run reaches PASS.
- **Stuck active.** Force `active`=1 after `instr_address`=0 with DRAIN_LIMIT=4. Required: `done`=1, `status`=FAIL after 4 enabled cycles.

Source files
------------

// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the MIPS run monitor.
//   mon_state_t  : monitor FSM states
//   run_status_t : verdict encoding driven on the monitor's status port
//   judge_v0     : PASS/FAIL decision for a clean halt
package mips_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } run_status_t;

    // A halt error (early active drop or stuck active) shares the FAIL code.
    localparam logic [1:0]  MON_HALT_ERR_CODE    = 2'd2;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] COUNT_MAX            = 32'hFFFF_FFFF;

    // Clean-halt verdict: unchecked runs always pass.
    function automatic run_status_t judge_v0(input logic        check_en,
                                             input logic [31:0] v0,
                                             input logic [31:0] expected);
        return (!check_en || (v0 == expected)) ? PASS : FAIL;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up counter that sticks at all-ones instead of wrapping.
//   clk, reset : clock, async active-low reset
//   en         : count one when high
//   clr        : synchronous clear, wins over en
//   count      : registered count value
module sat_counter32
    import mips_tb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != COUNT_MAX)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Watches a MIPS CPU from its reset-vector fetch to halt and reports a
// sticky verdict.
//   clk, reset      : clock, async active-low reset
//   clk_enable      : CPU clock enable; monitor only advances when high
//   active          : CPU active flag
//   instr_address   : CPU fetch address
//   register_v0     : CPU $v0 debug value
//   expected_v0     : reference result, sampled at capture
//   check_en        : compare captured $v0 against expected_v0
//   done            : verdict valid (sticky until reset)
//   status          : run_status_t verdict
//   final_v0        : $v0 captured at end of run
//   cycle_count     : enabled cycles spent in RUN and DRAIN
//   fetch_count     : enabled RUN cycles with active high
module mips_run_monitor
    import mips_tb_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned DRAIN_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_address,
    input  logic [31:0] register_v0,
    input  logic [31:0] expected_v0,
    input  logic        check_en,
    output logic        done,
    output run_status_t status,
    output logic [31:0] final_v0,
    output logic [31:0] cycle_count,
    output logic [31:0] fetch_count
);

    mon_state_t  state_q, state_d;
    logic        done_d;
    run_status_t status_d;
    logic [31:0] final_d;
    logic [31:0] drain_q, drain_d;

    logic start;
    logic halt_fetch;
    logic timeout_hit;
    logic drain_limit_hit;
    logic cyc_en;
    logic fetch_en;
    logic cnt_clr;

    // The start cycle is already counted as cycle 1 and fetch 1.
    assign start           = (state_q == IDLE) && active && (instr_address == RESET_VECTOR);
    assign halt_fetch      = (instr_address == HALT_ADDR);
    // Compare against the post-increment value, widened so all-ones cannot wrap.
    assign timeout_hit     = (33'(cycle_count) + 33'd1) >= 33'(TIMEOUT_CYCLES);
    assign drain_limit_hit = (33'(drain_q) + 33'd1) >= 33'(DRAIN_LIMIT);

    assign cyc_en   = clk_enable && (start || (state_q == RUN) || (state_q == DRAIN));
    assign fetch_en = clk_enable && (start || ((state_q == RUN) && active));
    // Counters are held at zero while waiting for a run to begin.
    assign cnt_clr  = clk_enable && (state_q == IDLE) && !start;

    sat_counter32 u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cyc_en),
        .clr   (cnt_clr),
        .count (cycle_count)
    );

    sat_counter32 u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (fetch_en),
        .clr   (cnt_clr),
        .count (fetch_count)
    );

    // Next-state and verdict logic.
    always_comb begin
        state_d  = state_q;
        done_d   = done;
        status_d = status;
        final_d  = final_v0;
        drain_d  = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Halt fetch outranks both early active drop and timeout.
                if (halt_fetch) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (!active) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = run_status_t'(MON_HALT_ERR_CODE);
                    final_d  = register_v0;
                end else if (timeout_hit) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = TIMEOUT;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 32'd1;
                if (!active) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = judge_v0(check_en, register_v0, expected_v0);
                    final_d  = register_v0;
                end else if (drain_limit_hit) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = run_status_t'(MON_HALT_ERR_CODE);
                    final_d  = register_v0;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; clk_enable low freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            done     <= 1'b0;
            status   <= NONE;
            final_v0 <= '0;
            drain_q  <= '0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            done     <= done_d;
            status   <= status_d;
            final_v0 <= final_d;
            drain_q  <= drain_d;
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench for mips_run_monitor: directed vector table, a few
// hand-written multi-cycle sequences, and randomized traces scored by a
// trace-level reference model.
module tb_mips_run_monitor;

    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] HALT = 32'h0000_0000;
    localparam int          T    = 20;
    localparam int          DL   = 4;
    localparam int          NR   = 48;
    localparam int          BIG  = 100000;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam logic [1:0] SN = 2'd0;
    localparam logic [1:0] SP = 2'd1;
    localparam logic [1:0] SF = 2'd2;
    localparam logic [1:0] ST = 2'd3;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        active;
    logic [31:0] instr_address;
    logic [31:0] register_v0;
    logic [31:0] expected_v0;
    logic        check_en;
    logic        done;
    logic [1:0]  status;
    logic [31:0] final_v0;
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    mips_run_monitor #(
        .RESET_VECTOR   (RV),
        .HALT_ADDR      (HALT),
        .TIMEOUT_CYCLES (T),
        .DRAIN_LIMIT    (DL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .active        (active),
        .instr_address (instr_address),
        .register_v0   (register_v0),
        .expected_v0   (expected_v0),
        .check_en      (check_en),
        .done          (done),
        .status        (status),
        .final_v0      (final_v0),
        .cycle_count   (cycle_count),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ce;
        bit          act;
        logic [31:0] addr;
        logic [31:0] v0;
        logic [31:0] ev;
        bit          chk;
        bit          e_done;
        logic [1:0]  e_st;
        logic [31:0] e_fin;
        logic [31:0] e_cyc;
        logic [31:0] e_fetch;
    } vec_t;

    vec_t tbl[$];

    // Random trace storage and model expectations.
    bit          t_ce  [NR];
    bit          t_act [NR];
    bit          t_chk [NR];
    logic [31:0] t_addr[NR];
    logic [31:0] t_v0  [NR];
    logic [31:0] t_ev  [NR];
    bit          x_done[NR];
    bit          x_fck [NR];
    logic [1:0]  x_st  [NR];
    logic [31:0] x_fin [NR];
    logic [31:0] x_cyc [NR];
    logic [31:0] x_fet [NR];
    int          n;

    function automatic vec_t mk(input bit rst, input bit ce, input bit act,
                                input logic [31:0] addr, input logic [31:0] v0,
                                input logic [31:0] ev, input bit chk,
                                input bit ed, input logic [1:0] es,
                                input logic [31:0] ef, input logic [31:0] ec,
                                input logic [31:0] efc);
        vec_t v;
        v.rst = rst; v.ce = ce; v.act = act; v.addr = addr; v.v0 = v0;
        v.ev = ev; v.chk = chk; v.e_done = ed; v.e_st = es; v.e_fin = ef;
        v.e_cyc = ec; v.e_fetch = efc;
        return v;
    endfunction

    // Four rows of the addiu / jr zero / delay-slot program up to the halt fetch.
    task automatic push_head(input logic [31:0] ev, input bit k);
        tbl.push_back(mk(H, H, H, RV,          32'd0, ev, k, L, SN, 32'd0, 32'd1, 32'd1));
        tbl.push_back(mk(L, H, H, RV + 32'd4,  32'd2, ev, k, L, SN, 32'd0, 32'd2, 32'd2));
        tbl.push_back(mk(L, H, H, RV + 32'd8,  32'd2, ev, k, L, SN, 32'd0, 32'd3, 32'd3));
        tbl.push_back(mk(L, H, H, HALT,        32'd2, ev, k, L, SN, 32'd0, 32'd4, 32'd4));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic check_outs(input string tag, input bit ed, input logic [1:0] es,
                              input logic [31:0] ef, input bit cf,
                              input logic [31:0] ec, input logic [31:0] efc);
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".status"}, 32'(status), 32'(es));
        if (cf) chk({tag, ".final_v0"}, final_v0, ef);
        chk({tag, ".cycle_count"}, cycle_count, ec);
        chk({tag, ".fetch_count"}, fetch_count, efc);
    endtask

    task automatic drive(input bit c, input bit a, input logic [31:0] ad,
                         input logic [31:0] v, input logic [31:0] e, input bit k);
        @(negedge clk);
        clk_enable    = c;
        active        = a;
        instr_address = ad;
        register_v0   = v;
        expected_v0   = e;
        check_en      = k;
        @(posedge clk);
        #1;
    endtask

    // Async reset with a start-like pattern on the inputs; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset         = 1'b0;
        clk_enable    = 1'b1;
        active        = 1'b1;
        instr_address = RV;
        #1;
        check_outs({tag, ".rst"}, L, SN, 32'd0, H, 32'd0, 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        active = 1'b0;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int cnt(input int a, input int b, input bit need_act);
        int c = 0;
        for (int i = a; i <= b; i++)
            if (t_ce[i] && (!need_act || t_act[i])) c++;
        return c;
    endfunction

    task automatic put_row(input bit a, input logic [31:0] ad, input bit k);
        if ((n < NR) && ($urandom_range(0, 3) == 0)) begin
            t_ce[n]  = 1'b0;
            t_act[n] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       t_addr[n] = HALT;
                1:       t_addr[n] = RV;
                default: t_addr[n] = $urandom();
            endcase
            t_v0[n] = $urandom_range(0, 3); t_ev[n] = $urandom_range(0, 3); t_chk[n] = k;
            n++;
        end
        if (n < NR) begin
            t_ce[n] = 1'b1; t_act[n] = a; t_addr[n] = ad;
            t_v0[n] = $urandom_range(0, 3); t_ev[n] = $urandom_range(0, 3); t_chk[n] = k;
            n++;
        end
    endtask

    // Whole-trace reference: locate start, the first run-ending event, then the
    // first drain-ending event, and derive counts by counting enabled cycles.
    task automatic run_model();
        int s, hi, ai, ti, re, di, li, e, rl, nn, m;
        logic [1:0]  fst;
        logic [31:0] ffin;
        bit          fck;
        s = BIG; hi = BIG; ai = BIG; ti = BIG; e = BIG; rl = NR - 1;
        fst = SN; ffin = 32'd0; fck = 1'b1;
        for (int i = 0; i < NR; i++)
            if ((s == BIG) && t_ce[i] && t_act[i] && (t_addr[i] == RV)) s = i;
        if (s != BIG) begin
            nn = 0;
            for (int i = s; i < NR; i++) begin
                if (t_ce[i]) begin
                    nn++;
                    if ((hi == BIG) && (t_addr[i] == HALT)) hi = i;
                    if ((ai == BIG) && !t_act[i]) ai = i;
                    if ((ti == BIG) && (nn == T)) ti = i;
                end
            end
            re = imin(hi, imin(ai, ti));
            if (re != BIG) rl = re;
            if (re == BIG) begin
                e = BIG;
            end else if (re == hi) begin
                di = BIG; li = BIG; m = 0;
                for (int j = hi + 1; j < NR; j++) begin
                    if (t_ce[j]) begin
                        m++;
                        if ((di == BIG) && !t_act[j]) di = j;
                        if ((li == BIG) && (m == DL)) li = j;
                    end
                end
                e = imin(di, li);
                if (e != BIG) begin
                    ffin = t_v0[e];
                    if (e == di) fst = (!t_chk[e] || (t_v0[e] == t_ev[e])) ? SP : SF;
                    else         fst = SF;
                end
            end else if (re == ai) begin
                e = ai; fst = SF; ffin = t_v0[ai];
            end else begin
                e = ti; fst = ST; fck = 1'b0;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if ((s == BIG) || (i < s)) begin
                x_done[i] = 1'b0; x_st[i] = SN; x_fin[i] = 32'd0; x_fck[i] = 1'b1;
                x_cyc[i] = 32'd0; x_fet[i] = 32'd0;
            end else begin
                x_cyc[i]  = 32'(cnt(s, imin(i, e), 1'b0));
                x_fet[i]  = 32'(cnt(s, imin(i, rl), 1'b1));
                x_done[i] = (i >= e);
                x_st[i]   = x_done[i] ? fst : SN;
                x_fin[i]  = x_done[i] ? ffin : 32'd0;
                x_fck[i]  = !x_done[i] || fck;
            end
        end
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b0; active = 1'b0; instr_address = 32'd0;
        register_v0 = 32'd0; expected_v0 = 32'd0; check_en = 1'b0;

        // Clean halt, correct v0; expected changing after capture is ignored.
        push_head(32'd2, H);
        tbl.push_back(mk(L, H, L, HALT, 32'd2, 32'd2, H, H, SP, 32'd2, 32'd5, 32'd4));
        tbl.push_back(mk(L, H, L, HALT, 32'd7, 32'd9, H, H, SP, 32'd2, 32'd5, 32'd4));
        // Clean halt, wrong v0.
        push_head(32'd3, H);
        tbl.push_back(mk(L, H, L, HALT, 32'd2, 32'd3, H, H, SF, 32'd2, 32'd5, 32'd4));
        tbl.push_back(mk(L, H, L, HALT, 32'd2, 32'd2, H, H, SF, 32'd2, 32'd5, 32'd4));
        // Five-cycle stall mid-run with halt-looking inputs; verdict as unstalled.
        tbl.push_back(mk(H, H, H, RV,         32'd0, 32'd2, H, L, SN, 32'd0, 32'd1, 32'd1));
        tbl.push_back(mk(L, H, H, RV + 32'd4, 32'd2, 32'd2, H, L, SN, 32'd0, 32'd2, 32'd2));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(L, L, L, HALT, 32'd2, 32'd2, H, L, SN, 32'd0, 32'd2, 32'd2));
        tbl.push_back(mk(L, H, H, RV + 32'd8, 32'd2, 32'd2, H, L, SN, 32'd0, 32'd3, 32'd3));
        tbl.push_back(mk(L, H, H, HALT,       32'd2, 32'd2, H, L, SN, 32'd0, 32'd4, 32'd4));
        tbl.push_back(mk(L, H, L, HALT,       32'd2, 32'd2, H, H, SP, 32'd2, 32'd5, 32'd4));
        // Stuck active after the halt fetch.
        push_head(32'd5, H);
        tbl.push_back(mk(L, H, H, RV + 32'd16, 32'd5, 32'd5, H, L, SN, 32'd0, 32'd5, 32'd4));
        tbl.push_back(mk(L, H, H, RV + 32'd16, 32'd5, 32'd5, H, L, SN, 32'd0, 32'd6, 32'd4));
        tbl.push_back(mk(L, H, H, RV + 32'd16, 32'd5, 32'd5, H, L, SN, 32'd0, 32'd7, 32'd4));
        tbl.push_back(mk(L, H, H, RV + 32'd16, 32'd5, 32'd5, H, H, SF, 32'd5, 32'd8, 32'd4));
        tbl.push_back(mk(L, H, L, HALT,        32'd1, 32'd1, H, H, SF, 32'd5, 32'd8, 32'd4));
        // Wrong v0 with checking disabled still passes.
        push_head(32'd99, L);
        tbl.push_back(mk(L, H, L, HALT, 32'd2, 32'd99, L, H, SP, 32'd2, 32'd5, 32'd4));
        // Start qualification, then active dropping in RUN without a halt fetch.
        tbl.push_back(mk(H, H, H, RV + 32'd4, 32'd0, 32'd0, H, L, SN, 32'd0, 32'd0, 32'd0));
        tbl.push_back(mk(L, H, L, RV,         32'd0, 32'd0, H, L, SN, 32'd0, 32'd0, 32'd0));
        tbl.push_back(mk(L, L, H, RV,         32'd0, 32'd0, H, L, SN, 32'd0, 32'd0, 32'd0));
        tbl.push_back(mk(L, H, H, RV,         32'd0, 32'd0, H, L, SN, 32'd0, 32'd1, 32'd1));
        tbl.push_back(mk(L, H, L, RV + 32'd4, 32'd9, 32'd0, H, H, SF, 32'd9, 32'd2, 32'd1));
        // Stall inside DRAIN, then capture.
        tbl.push_back(mk(H, H, H, RV,   32'd0, 32'd4, H, L, SN, 32'd0, 32'd1, 32'd1));
        tbl.push_back(mk(L, H, H, HALT, 32'd4, 32'd4, H, L, SN, 32'd0, 32'd2, 32'd2));
        tbl.push_back(mk(L, L, L, HALT, 32'd4, 32'd4, H, L, SN, 32'd0, 32'd2, 32'd2));
        tbl.push_back(mk(L, H, L, HALT, 32'd4, 32'd4, H, H, SP, 32'd4, 32'd3, 32'd2));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset($sformatf("tbl%0d", i));
            drive(tbl[i].ce, tbl[i].act, tbl[i].addr, tbl[i].v0, tbl[i].ev, tbl[i].chk);
            check_outs($sformatf("tbl%0d", i), tbl[i].e_done, tbl[i].e_st, tbl[i].e_fin, H,
                       tbl[i].e_cyc, tbl[i].e_fetch);
        end

        // Timeout on a self-loop; frozen afterwards even with halt-like inputs.
        do_reset("to");
        drive(H, H, RV, 32'd0, 32'd0, H);
        check_outs("to.c1", L, SN, 32'd0, L, 32'd1, 32'd1);
        for (int k = 2; k <= T; k++) begin
            drive(H, H, RV + 32'd4, 32'd0, 32'd0, H);
            check_outs($sformatf("to.c%0d", k), (k == T), (k == T) ? ST : SN, 32'd0, L,
                       32'(k), 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            drive(H, L, HALT, 32'd3, 32'd3, H);
            check_outs($sformatf("to.hold%0d", k), H, ST, 32'd0, L, 32'(T), 32'(T));
        end

        // Halt fetch landing on the timeout cycle wins.
        do_reset("tie");
        drive(H, H, RV, 32'd0, 32'd2, H);
        for (int k = 2; k < T; k++) drive(H, H, RV + 32'd4, 32'd2, 32'd2, H);
        drive(H, H, HALT, 32'd2, 32'd2, H);
        check_outs("tie.halt", L, SN, 32'd0, H, 32'(T), 32'(T));
        drive(H, L, HALT, 32'd2, 32'd2, H);
        check_outs("tie.cap", H, SP, 32'd2, H, 32'(T + 1), 32'(T));

        // Reset asserted one cycle after the halt fetch, between clock edges.
        do_reset("rd");
        drive(H, H, RV,         32'd0, 32'd2, H);
        drive(H, H, RV + 32'd4, 32'd2, 32'd2, H);
        drive(H, H, RV + 32'd8, 32'd2, 32'd2, H);
        drive(H, H, HALT,       32'd2, 32'd2, H);
        @(negedge clk);
        active = 1'b1; instr_address = RV + 32'd16;
        #2;
        reset = 1'b0;
        #1;
        check_outs("rd.async", L, SN, 32'd0, H, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check_outs("rd.held", L, SN, 32'd0, H, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1; active = 1'b0;
        drive(H, H, RV,         32'd0, 32'd2, H);
        drive(H, H, RV + 32'd4, 32'd2, 32'd2, H);
        drive(H, H, RV + 32'd8, 32'd2, 32'd2, H);
        drive(H, H, HALT,       32'd2, 32'd2, H);
        drive(H, L, HALT,       32'd2, 32'd2, H);
        check_outs("rd.rerun", H, SP, 32'd2, H, 32'd5, 32'd4);

        // Randomized traces against the reference model.
        for (int tr = 0; tr < 25; tr++) begin
            bit kchk;
            int pre, rlen, dlen;
            kchk = 1'($urandom_range(0, 1));
            n = 0;
            pre = $urandom_range(0, 3);
            for (int j = 0; j < pre; j++) put_row(1'($urandom_range(0, 1)), $urandom() | 32'h1, kchk);
            put_row(H, RV, kchk);
            rlen = $urandom_range(0, 24);
            for (int j = 0; j < rlen; j++) put_row(($urandom_range(0, 15) != 0), $urandom() | 32'h1, kchk);
            put_row(H, HALT, kchk);
            dlen = $urandom_range(0, 5);
            for (int j = 0; j < dlen; j++) put_row(H, $urandom() | 32'h1, kchk);
            while (n < NR) put_row(L, $urandom() | 32'h1, kchk);
            run_model();
            do_reset($sformatf("rnd%0d", tr));
            for (int i = 0; i < NR; i++) begin
                drive(t_ce[i], t_act[i], t_addr[i], t_v0[i], t_ev[i], t_chk[i]);
                check_outs($sformatf("rnd%0d.%0d", tr, i), x_done[i], x_st[i], x_fin[i],
                           x_fck[i], x_cyc[i], x_fet[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
